video_frame_monitor: RTL
========================

VIDEO_FRAME_MONITOR -- requirements
Module: video_frame_monitor

Interface
REQ-001 SHALL have parameter C_CHANNELS, default 3, number of colour channels packed in DATA.
REQ-002 SHALL have parameter C_BPC, default 12, bits per channel on DATA.
REQ-003 SHALL have parameter C_OUT_BPC, default 8 (1..C_BPC), MSBs kept per channel on PIX_DATA.
REQ-004 SHALL have parameter C_CNT_WIDTH, default 12, width of all timing counters.
REQ-005 SHALL have port CLK  input  1  single clock.
REQ-006 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports DE, HSYNC, VSYNC  input  1 each  video timing strobes.
REQ-008 SHALL have port DATA  input  C_CHANNELS*C_BPC  pixel, channel 0 in LSBs.
REQ-009 SHALL have ports HS_POL, VS_POL  input  1 each  1 = sync active-low.
REQ-010 SHALL have port START  input  1  one-cycle pulse, re-arm capture.
REQ-011 SHALL have port FRAME_TARGET  input  8  frames to capture; 0 = free-run.
REQ-012 SHALL have port BUSY  output  1  capture in progress.
REQ-013 SHALL have port INTR  output  1  one-cycle done pulse.
REQ-014 SHALL have port FRAME_COUNT  output  8  completed frames since arm.
REQ-015 SHALL have ports H_ACTIVE, V_ACTIVE, H_TOTAL  output  C_CNT_WIDTH each  last-frame geometry.
REQ-016 SHALL have port FRAME_SUM  output  32  last-frame pixel signature.
REQ-017 SHALL have port ERR_LINE  output  1  sticky line-length mismatch.
REQ-018 SHALL have ports PIX_VALID  output  1, PIX_DATA  output  C_CHANNELS*C_OUT_BPC  decimated pixel.

Function
REQ-019 SHALL normalise syncs: hs = HSYNC^HS_POL, vs = VSYNC^VS_POL; all edge detection uses one registered copy of hs and vs.
REQ-020 SHALL define end-of-frame (EOF) as registered vs=1 and current vs=0 (falling edge of normalised vsync).
REQ-021 SHALL register PIX_VALID=DE and PIX_DATA = top C_OUT_BPC bits of each channel, latency 1 cycle, regardless of BUSY.
REQ-022 SHALL count DE-high cycles per line; on DE falling edge, the count is the line length, and the line counter increments.
REQ-023 SHALL count CLK cycles between successive hs rising edges; on each hs rising edge the count (inclusive of the edge cycle) becomes the line total.
REQ-024 SHALL set ERR_LINE when a line length differs from the first line length of the same frame; cleared only by START or reset.
REQ-025 SHALL update signature on each DE cycle: sum <= {sum[30:0],sum[31]} XOR zero-extended/truncated-to-32 {PIX_DATA-equivalent of current DATA}.
REQ-026 SHALL on EOF latch H_ACTIVE=first line length, V_ACTIVE=line count, H_TOTAL=last line total, FRAME_SUM=signature, then clear per-frame counters and signature in the same cycle.
REQ-027 SHALL saturate all C_CNT_WIDTH counters at all-ones, never wrap.
REQ-028 SHALL states: IDLE (BUSY=0), ARMED (BUSY=1, waiting first EOF to align), CAPTURE (BUSY=1).
REQ-029 SHALL START in any state: FRAME_COUNT=0, ERR_LINE=0, go ARMED next cycle; START wins over simultaneous EOF.
REQ-030 SHALL ARMED -> CAPTURE on first EOF, that EOF not counted and not latching geometry.
REQ-031 SHALL in CAPTURE increment FRAME_COUNT (saturating at 255) on each EOF; when new count equals nonzero FRAME_TARGET assert INTR for one cycle and go IDLE.
REQ-032 SHALL with FRAME_TARGET=0 stay in CAPTURE, never assert INTR.
REQ-033 SHALL in IDLE keep geometry/signature outputs frozen and ignore EOF.

Reset
REQ-034 SHALL on nRST low asynchronously force: state ARMED, BUSY=1, INTR=0, FRAME_COUNT=0, ERR_LINE=0, PIX_VALID=0, PIX_DATA=0, H_ACTIVE=V_ACTIVE=H_TOTAL=0, FRAME_SUM=0, all internal counters/edge registers 0.
REQ-035 SHALL, on reset mid-frame, discard the partial frame; first EOF after release only aligns (REQ-030).

Verification
REQ-036 SHALL test: 16x4 active, htotal 24, 6 lines/frame, FRAME_TARGET=2, polarities 0 -> INTR one cycle at third vsync fall, BUSY=0, FRAME_COUNT=2, H_ACTIVE=16, V_ACTIVE=4, H_TOTAL=24.
REQ-037 SHALL test: same stream, HS_POL=VS_POL=1 with inverted syncs -> identical results.
REQ-038 SHALL test: constant DATA=0, 2 frames -> FRAME_SUM=0; single pixel 36'hFFF_FFF_FFF at first active cycle, 16 px -> FRAME_SUM = 32'h00FFFFFF rotated left 15.
REQ-039 SHALL test: one line of 15 active pixels in a 16-wide frame -> ERR_LINE=1 until START.
REQ-040 SHALL test: START coincident with EOF in CAPTURE -> FRAME_COUNT=0, state ARMED, no INTR; FRAME_TARGET=0 over 5 frames -> no INTR, FRAME_COUNT=5.
REQ-041 SHALL test: nRST pulsed mid-line -> all outputs at REQ-034 values immediately, capture resumes after one alignment EOF.

Source files
------------

// File: rtl/video_frame_monitor.sv
// Video timing monitor: measures active/total geometry and a pixel signature per frame,
// counts captured frames against a target, and forwards a bit-depth-reduced pixel stream.
module video_frame_monitor #(
    parameter int unsigned C_CHANNELS  = 3,
    parameter int unsigned C_BPC       = 12,
    parameter int unsigned C_OUT_BPC   = 8,
    parameter int unsigned C_CNT_WIDTH = 12
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              DE,
    input  logic                              HSYNC,
    input  logic                              VSYNC,
    input  logic [C_CHANNELS*C_BPC-1:0]       DATA,
    input  logic                              HS_POL,
    input  logic                              VS_POL,
    input  logic                              START,
    input  logic [7:0]                        FRAME_TARGET,
    output logic                              BUSY,
    output logic                              INTR,
    output logic [7:0]                        FRAME_COUNT,
    output logic [C_CNT_WIDTH-1:0]            H_ACTIVE,
    output logic [C_CNT_WIDTH-1:0]            V_ACTIVE,
    output logic [C_CNT_WIDTH-1:0]            H_TOTAL,
    output logic [31:0]                       FRAME_SUM,
    output logic                              ERR_LINE,
    output logic                              PIX_VALID,
    output logic [C_CHANNELS*C_OUT_BPC-1:0]   PIX_DATA
);

    localparam int unsigned OUT_W = C_CHANNELS * C_OUT_BPC;
    localparam int unsigned CW    = C_CNT_WIDTH;
    localparam int unsigned DROP  = C_BPC - C_OUT_BPC;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic hs_c, vs_c, hs_q, vs_q;
    logic eof_c, hs_rise_c, de_fall_c, err_c, latch_c;
    logic data_unused_c;

    logic [OUT_W-1:0] pix_dec_c;
    logic [31:0]      sig_pix_c;
    logic [31:0]      sum_q;
    logic [CW-1:0]    de_cnt_q, line_cnt_q, first_len_q, htot_cnt_q, line_total_q;
    logic [7:0]       count_d;
    logic             intr_d, busy_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // Keep the top C_OUT_BPC bits of every channel
    always_comb begin
        pix_dec_c = '0;
        for (int unsigned c = 0; c < C_CHANNELS; c++) begin
            pix_dec_c[c*C_OUT_BPC +: C_OUT_BPC] = DATA[c*C_BPC + DROP +: C_OUT_BPC];
        end
    end

    assign data_unused_c = ^DATA;
    assign sig_pix_c     = 32'(pix_dec_c);

    assign hs_c      = HSYNC ^ HS_POL;
    assign vs_c      = VSYNC ^ VS_POL;
    assign eof_c     = vs_q & ~vs_c;
    assign hs_rise_c = hs_c & ~hs_q;
    assign de_fall_c = PIX_VALID & ~DE;
    assign err_c     = de_fall_c && (line_cnt_q != '0) && (de_cnt_q != first_len_q)
                       && (state_q == ST_CAPTURE);

    // Sync edge registers and the one-cycle pixel pass-through
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            PIX_VALID <= 1'b0;
            PIX_DATA  <= '0;
        end else begin
            hs_q      <= hs_c;
            vs_q      <= vs_c;
            PIX_VALID <= DE;
            PIX_DATA  <= pix_dec_c;
        end
    end

    // Line/frame measurement; EOF restarts the per-frame accumulators
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            de_cnt_q     <= '0;
            line_cnt_q   <= '0;
            first_len_q  <= '0;
            htot_cnt_q   <= '0;
            line_total_q <= '0;
            sum_q        <= '0;
        end else begin
            de_cnt_q <= DE ? sat_inc(de_cnt_q) : '0;

            if (hs_rise_c) begin
                htot_cnt_q   <= '0;
                line_total_q <= sat_inc(htot_cnt_q);
            end else begin
                htot_cnt_q <= sat_inc(htot_cnt_q);
            end

            if (eof_c) begin
                line_cnt_q  <= '0;
                first_len_q <= '0;
                sum_q       <= '0;
            end else begin
                if (de_fall_c) begin
                    line_cnt_q <= sat_inc(line_cnt_q);
                    if (line_cnt_q == '0) begin
                        first_len_q <= de_cnt_q;
                    end
                end
                if (DE) begin
                    sum_q <= {sum_q[30:0], sum_q[31]} ^ sig_pix_c;
                end
            end
        end
    end

    // Capture control: START always re-arms and beats a coincident EOF
    always_comb begin
        state_d = state_q;
        count_d = FRAME_COUNT;
        intr_d  = 1'b0;
        latch_c = 1'b0;
        if (START) begin
            state_d = ST_ARMED;
            count_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED: begin
                    if (eof_c) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (eof_c) begin
                        latch_c = 1'b1;
                        count_d = (FRAME_COUNT == 8'hFF) ? FRAME_COUNT : FRAME_COUNT + 8'd1;
                        if ((FRAME_TARGET != 8'd0) && (count_d == FRAME_TARGET)) begin
                            intr_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_ARMED;
            BUSY        <= 1'b1;
            INTR        <= 1'b0;
            FRAME_COUNT <= 8'd0;
            ERR_LINE    <= 1'b0;
            H_ACTIVE    <= '0;
            V_ACTIVE    <= '0;
            H_TOTAL     <= '0;
            FRAME_SUM   <= '0;
        end else begin
            state_q     <= state_d;
            BUSY        <= busy_d;
            INTR        <= intr_d;
            FRAME_COUNT <= count_d;
            ERR_LINE    <= START ? 1'b0 : (ERR_LINE | err_c);
            if (latch_c) begin
                H_ACTIVE  <= first_len_q;
                V_ACTIVE  <= line_cnt_q;
                H_TOTAL   <= line_total_q;
                FRAME_SUM <= sum_q;
            end
        end
    end

endmodule
